// File: rtl/fwd_scoreboard.sv
// Forwarding and load-use hazard unit: tracks destination tags of in-flight
// instructions and picks the youngest producer for each decode-stage operand.
module fwd_scoreboard #(
  parameter int REG_AW     = 5,
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 3,
  parameter int LOAD_READY = 2,
  parameter int SEL_W      = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      issue_valid,
  input  logic                      issue_wr,
  input  logic [REG_AW-1:0]         issue_rw,
  input  logic                      issue_load,
  input  logic [NUM_SRC*REG_AW-1:0] src_addr,
  input  logic [NUM_SRC-1:0]        src_used,
  input  logic                      pipe_hold,
  input  logic                      flush,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
  output logic                      stall,
  output logic [15:0]               stall_count
);

  logic [DEPTH:1]    stValid;
  logic [DEPTH:1]    stWr;
  logic [DEPTH:1]    stLd;
  logic [REG_AW-1:0] stRw [1:DEPTH];

  logic [REG_AW-1:0] srcAddr;
  logic              found;
  logic              hazard;

  // Scan stages from youngest to oldest; the first hit decides both the
  // forward select and whether that operand must wait for a load.
  always_comb begin
    fwd_sel = '0;
    hazard  = 1'b0;
    srcAddr = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      srcAddr = src_addr[i*REG_AW +: REG_AW];
      found   = 1'b0;
      for (int k = 1; k <= DEPTH; k++) begin
        if (!found && src_used[i] && stValid[k] && stWr[k] &&
            (stRw[k] != '0) && (stRw[k] == srcAddr)) begin
          found = 1'b1;
          fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k);
          if (stLd[k] && (k < LOAD_READY)) begin
            hazard = 1'b1;
          end
        end
      end
    end
  end

  assign stall = issue_valid & ~flush & hazard;

  // A stalled or flushed decode instruction enters stage 1 as a bubble while
  // older stages keep draining.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stValid     <= '0;
      stall_count <= '0;
    end else if (!pipe_hold) begin
      for (int k = DEPTH; k >= 2; k--) begin
        stValid[k] <= stValid[k-1];
        stWr[k]    <= stWr[k-1];
        stLd[k]    <= stLd[k-1];
        stRw[k]    <= stRw[k-1];
      end
      stValid[1] <= issue_valid & ~stall & ~flush;
      stWr[1]    <= issue_wr;
      stLd[1]    <= issue_load;
      stRw[1]    <= issue_rw;
      if (stall && (stall_count != 16'hFFFF)) begin
        stall_count <= stall_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard: directed vector table, randomized
// traffic against an age-based producer model, and a stall-counter saturation run.
module tb_fwd_scoreboard;

  localparam int REG_AW     = 5;
  localparam int DEPTH      = 3;
  localparam int LOAD_READY = 2;
  localparam int SAT_DEPTH  = 32;

  typedef struct {
    int rstn, hold, flush, valid, wr, ld;
    int rw, s0, s1, used;
    int eSel0, eSel1, eStall, eCount;
  } vec_t;

  typedef struct {
    logic [4:0] rw;
    bit         wr;
    bit         ld;
    int         issuedAt;
  } prod_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issueValid, issueWr, issueLoad, pipeHold, flush;
  logic [4:0]  issueRw;
  logic [9:0]  srcAddr;
  logic [1:0]  srcUsed;
  logic [3:0]  fwdSel;
  logic        stall;
  logic [15:0] stallCount;

  logic        satRstN;
  logic [11:0] satSel;
  logic        satStall;
  logic [15:0] satCount;

  int nCompared   = 0;
  int nMismatched = 0;

  prod_t inflight[$];
  int    advCount = 0;
  int    mSel[2];
  int    mStall;
  int    mCount = 0;

  vec_t vecs[28];

  always #5 clk = ~clk;

  fwd_scoreboard #(.REG_AW(REG_AW), .NUM_SRC(2), .DEPTH(DEPTH), .LOAD_READY(LOAD_READY)) dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issueValid), .issue_wr(issueWr),
    .issue_rw(issueRw), .issue_load(issueLoad), .src_addr(srcAddr), .src_used(srcUsed),
    .pipe_hold(pipeHold), .flush(flush), .fwd_sel(fwdSel), .stall(stall),
    .stall_count(stallCount)
  );

  // Every cycle presents a load of r4 that also reads r4, so the unit stalls
  // until the previous load reaches the last stage.
  fwd_scoreboard #(.REG_AW(REG_AW), .NUM_SRC(2), .DEPTH(SAT_DEPTH), .LOAD_READY(SAT_DEPTH)) satDut (
    .clk(clk), .rst_n(satRstN), .issue_valid(1'b1), .issue_wr(1'b1),
    .issue_rw(5'd4), .issue_load(1'b1), .src_addr({5'd0, 5'd4}), .src_used(2'b01),
    .pipe_hold(1'b0), .flush(1'b0), .fwd_sel(satSel), .stall(satStall),
    .stall_count(satCount)
  );

  function automatic vec_t mkVec(input int rstn, hold, fl, valid, wr, ld, rw, s0, s1, used,
                                 input int e0, e1, eSt, eCnt);
    vec_t v;
    v.rstn = rstn; v.hold = hold; v.flush = fl; v.valid = valid; v.wr = wr; v.ld = ld;
    v.rw = rw; v.s0 = s0; v.s1 = s1; v.used = used;
    v.eSel0 = e0; v.eSel1 = e1; v.eStall = eSt; v.eCount = eCnt;
    return v;
  endfunction

  task automatic compare(input string tag, input logic [31:0] act, input int exp);
    nCompared++;
    if (act !== 32'(exp)) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, want %0d", tag, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst_n      = (v.rstn != 0);
    pipeHold   = (v.hold != 0);
    flush      = (v.flush != 0);
    issueValid = (v.valid != 0);
    issueWr    = (v.wr != 0);
    issueLoad  = (v.ld != 0);
    issueRw    = 5'(v.rw);
    srcAddr    = {5'(v.s1), 5'(v.s0)};
    srcUsed    = 2'(v.used);
  endtask

  task automatic checkOutput(input string name, input int e0, e1, eSt, eCnt);
    compare({name, ".sel0"},  32'(fwdSel[1:0]), e0);
    compare({name, ".sel1"},  32'(fwdSel[3:2]), e1);
    compare({name, ".stall"}, 32'(stall), eSt);
    compare({name, ".count"}, 32'(stallCount), eCnt);
  endtask

  // Reference: a producer's stage is simply how many advances it has seen.
  task automatic modelEval();
    int notReady;
    notReady = 0;
    for (int i = 0; i < 2; i++) begin
      int best;
      bit bestLd;
      best   = DEPTH + 1;
      bestLd = 1'b0;
      foreach (inflight[j]) begin
        int age;
        age = advCount - inflight[j].issuedAt + 1;
        if (srcUsed[i] && inflight[j].wr && (inflight[j].rw != 5'd0) &&
            (inflight[j].rw == srcAddr[i*5 +: 5]) && (age < best)) begin
          best   = age;
          bestLd = inflight[j].ld;
        end
      end
      mSel[i] = (best <= DEPTH) ? best : 0;
      if ((best <= DEPTH) && bestLd && (best < LOAD_READY)) notReady = 1;
    end
    mStall = (issueValid && !flush && (notReady != 0)) ? 1 : 0;
  endtask

  task automatic modelAdvance();
    if (!rst_n) begin
      inflight.delete();
      mCount = 0;
    end else if (!pipeHold) begin
      advCount++;
      if ((mStall != 0) && (mCount < 65535)) mCount++;
      if (issueValid && (mStall == 0) && !flush)
        inflight.push_back('{issueRw, issueWr, issueLoad, advCount});
      while ((inflight.size() > 0) && (advCount - inflight[0].issuedAt + 1 > DEPTH))
        void'(inflight.pop_front());
    end
  endtask

  function automatic int satExpected(input int c);
    int n;
    n = c - (c + SAT_DEPTH - 1) / SAT_DEPTH;
    return (n > 65535) ? 65535 : n;
  endfunction

  initial begin
    vec_t v;
    vecs[0]  = mkVec(1,0,0, 1,1,0,  3,  0, 0, 0,  0,0,0,0);
    vecs[1]  = mkVec(1,0,0, 0,0,0,  0,  3, 0, 1,  1,0,0,0);
    vecs[2]  = mkVec(1,0,0, 0,0,0,  0,  3, 0, 1,  2,0,0,0);
    vecs[3]  = mkVec(1,0,0, 0,0,0,  0,  3, 0, 1,  3,0,0,0);
    vecs[4]  = mkVec(1,0,0, 0,0,0,  0,  3, 0, 1,  0,0,0,0);
    vecs[5]  = mkVec(1,0,0, 1,1,0,  5,  0, 0, 0,  0,0,0,0);
    vecs[6]  = mkVec(1,0,0, 1,1,0,  5,  0, 0, 0,  0,0,0,0);
    vecs[7]  = mkVec(1,0,0, 0,0,0,  0,  5, 5, 3,  1,1,0,0);
    vecs[8]  = mkVec(1,0,0, 1,1,0,  0,  0, 0, 0,  0,0,0,0);
    vecs[9]  = mkVec(1,0,0, 0,0,0,  0,  0, 0, 3,  0,0,0,0);
    vecs[10] = mkVec(1,0,0, 1,1,1,  7,  0, 0, 0,  0,0,0,0);
    vecs[11] = mkVec(1,0,0, 1,1,0,  8,  7, 0, 1,  1,0,1,0);
    vecs[12] = mkVec(1,0,0, 1,1,0,  8,  7, 0, 1,  2,0,0,1);
    vecs[13] = mkVec(1,0,0, 1,1,1,  9,  0, 0, 0,  0,0,0,1);
    vecs[14] = mkVec(1,1,0, 1,1,0, 10,  9, 0, 1,  1,0,1,1);
    vecs[15] = mkVec(1,1,0, 1,1,0, 10,  9, 0, 1,  1,0,1,1);
    vecs[16] = mkVec(1,1,0, 1,1,0, 10,  9, 0, 1,  1,0,1,1);
    vecs[17] = mkVec(1,1,0, 1,1,0, 10,  9, 0, 1,  1,0,1,1);
    vecs[18] = mkVec(1,0,0, 1,1,0, 10,  9, 0, 1,  1,0,1,1);
    vecs[19] = mkVec(1,0,0, 1,1,0, 10,  9, 0, 1,  2,0,0,2);
    vecs[20] = mkVec(1,0,0, 1,1,1, 11,  0, 0, 0,  0,0,0,2);
    vecs[21] = mkVec(1,0,1, 1,1,0, 11, 11, 0, 1,  1,0,0,2);
    vecs[22] = mkVec(1,0,0, 0,0,0,  0, 11, 0, 1,  2,0,0,2);
    vecs[23] = mkVec(1,0,0, 1,1,0,  1,  0, 0, 0,  0,0,0,2);
    vecs[24] = mkVec(1,0,0, 1,1,0,  2,  0, 0, 0,  0,0,0,2);
    vecs[25] = mkVec(1,0,0, 1,1,0,  3,  0, 0, 0,  0,0,0,2);
    vecs[26] = mkVec(0,1,0, 0,0,0,  0,  1, 3, 3,  3,1,0,2);
    vecs[27] = mkVec(1,0,0, 0,0,0,  0,  1, 3, 3,  0,0,0,0);

    satRstN = 1'b0;
    applyStimulus(mkVec(0,0,0, 0,0,0, 0, 0,0,0, 0,0,0,0));
    repeat (2) begin
      modelEval();
      @(posedge clk);
      modelAdvance();
      #1;
    end

    applyStimulus(mkVec(1,0,0, 0,0,0, 0, 0,0,0, 0,0,0,0));
    modelEval();
    @(negedge clk);
    checkOutput("reset", 0, 0, 0, 0);
    @(posedge clk);
    modelAdvance();
    #1;

    for (int i = 0; i < 28; i++) begin
      applyStimulus(vecs[i]);
      modelEval();
      @(negedge clk);
      checkOutput($sformatf("vec%0d", i), vecs[i].eSel0, vecs[i].eSel1, vecs[i].eStall, vecs[i].eCount);
      @(posedge clk);
      modelAdvance();
      #1;
    end

    for (int n = 0; n < 400; n++) begin
      v = mkVec(($urandom_range(0, 39) != 0) ? 1 : 0,
                ($urandom_range(0, 5) == 0) ? 1 : 0,
                ($urandom_range(0, 7) == 0) ? 1 : 0,
                ($urandom_range(0, 3) != 0) ? 1 : 0,
                ($urandom_range(0, 3) != 0) ? 1 : 0,
                ($urandom_range(0, 2) == 0) ? 1 : 0,
                int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                0, 0, 0, 0);
      applyStimulus(v);
      modelEval();
      @(negedge clk);
      checkOutput($sformatf("rand%0d", n), mSel[0], mSel[1], mStall, mCount);
      @(posedge clk);
      modelAdvance();
      #1;
    end

    satRstN = 1'b1;
    for (int c = 0; c < 67700; c++) begin
      @(negedge clk);
      if ((c == 0) || (c == 1) || (c == 31) || (c == 32) || (c == 33))
        compare($sformatf("sat.stall%0d", c), 32'(satStall), ((c % SAT_DEPTH) != 0) ? 1 : 0);
      if ((c == 100) || (c == 67648) || (c == 67649) || (c == 67650) || (c == 67699))
        compare($sformatf("sat.count%0d", c), 32'(satCount), satExpected(c));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised forwarding and hazard unit for the pipelined MIPS datapath; successor to the fixed two-stage ALU/RF forward selectors.
- Tracks the destination register of every in-flight instruction through DEPTH post-decode stages in an internal tag pipeline.
- For each of NUM_SRC decode-stage source operands, selects the youngest valid producer stage.
- Raises a load-use stall when that producer's result is not yet available, and counts stall cycles.

Parameters:
- REG_AW, 5, register address width; address 0 is hardwired zero and never matches.
- NUM_SRC, 2, number of source operands checked per cycle.
- DEPTH, 3, number of tracked stages; stage 1 = EX, 2 = MEM, 3 = WB by default.
- LOAD_READY, 2, first stage at which a load result is forwardable (1 <= LOAD_READY <= DEPTH).
- SEL_W, $clog2(DEPTH+1), width of each forward select.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous reset, active-low.
- issue_valid  in  1  decode-stage instruction valid.
- issue_wr  in  1  decode instruction writes the register file.
- issue_rw  in  REG_AW  decode instruction destination register.
- issue_load  in  1  decode instruction is a load.
- src_addr  in  NUM_SRC*REG_AW  source addresses, operand i at bits [i*REG_AW +: REG_AW].
- src_used  in  NUM_SRC  operand i is actually read by the instruction.
- pipe_hold  in  1  global freeze (e.g. memory wait); no state change.
- flush  in  1  kill the decode instruction (branch taken).
- fwd_sel  out  NUM_SRC*SEL_W  per operand: 0 = register file, k = stage k result.
- stall  out  1  load-use stall; decode and PC must hold.
- stall_count  out  16  saturating count of stall cycles.

Behaviour:
- State: per stage k (1..DEPTH): v[k], wr[k], rw[k], ld[k].
- Reset (rst_n=0 at a clk edge): all v=0, stall_count=0. Consequently fwd_sel=0 and stall=0.
- Match, per operand i and stage k: src_used[i] & v[k] & wr[k] & (rw[k]!=0) & (rw[k]==src_addr_i).
- Youngest match wins: the lowest k has priority.
- fwd_sel_i is the lowest matching k, or 0 if there is no match. It is combinational from state and inputs.
- A matching stage k is not ready when ld[k]=1 and k < LOAD_READY.
- stall = issue_valid & ~flush & (any operand's selected stage is not ready). Only the youngest match is evaluated.
- While stall=1, fwd_sel is still driven but the datapath ignores it.
- Advance, on each clk edge with rst_n=1 and pipe_hold=0:
  - stage k+1 takes stage k;
  - stage DEPTH's old contents are discarded;
  - stage 1 takes {issue_valid & ~stall & ~flush, issue_wr, issue_rw, issue_load}.
- A stall therefore inserts exactly one bubble into stage 1 per stalled cycle, while older stages continue draining.
- pipe_hold=1: all stage state is frozen and stall_count is unchanged. fwd_sel and stall are still computed from the frozen state.
- pipe_hold has priority over advance; rst_n has priority over pipe_hold.
- flush=1 with a hazard present: stall=0 and a bubble enters stage 1.
- stall_count increments by 1 on each advancing edge where stall=1, and saturates at 16'hFFFF.
- Mid-operation reset: all entries are invalidated on that edge; the next cycle shows fwd_sel=0 and stall=0.
- Latency: a producer issued at edge N is forwardable from cycle N+1 (ALU op) or from cycle N+LOAD_READY (load).
- After DEPTH advances the producer's tag has left the unit; the value must come from the register file, which is write-through.
- Back-to-back stalls: with defaults, a load followed immediately by a dependent instruction stalls exactly 1 cycle. With LOAD_READY=L it stalls L-1 cycles.

Test Plan:
- Reset, then issue add r3 (wr=1, rw=3). Next cycle src_addr0=3, src_used=2'b01 -> fwd_sel0=1, stall=0. One advance later with the same source -> fwd_sel0=2, then 3, then 0.
- Issue r5 at stage 2 and r5 again at stage 1; read r5 -> fwd_sel=1 (youngest wins). Repeat with rw=0 and source 0 -> fwd_sel=0.
- Load r7 (issue_load=1), then decode reads r7 -> stall=1 for exactly 1 cycle with a bubble in stage 1. Next cycle fwd_sel=2, stall=0; stall_count=1.
- Load-use hazard with pipe_hold=1 for 4 cycles -> stall stays 1, state frozen, stall_count unchanged. Release hold -> stall clears after one advance.
- Load-use hazard with flush=1 -> stall=0 and stage 1 gets v=0. A following read of the same register at stage 2 -> fwd_sel=2 (the load only, not the flushed instruction).
- Drive rst_n=0 for one edge with 3 valid entries -> all fwd_sel=0 and stall=0 next cycle. Force 65536 stall cycles -> stall_count holds at 16'hFFFF.
